// File: rtl/micro_seq_pkg.sv
// Shared constants for the microprogrammed control sequencer: next-address
// modes, condition selects, microstore state numbers and IR decode values.
package micro_seq_pkg;

    // Next-address modes carried in the microstore n_sel field
    localparam logic [2:0] NSEL_DECODE   = 3'b000;
    localparam logic [2:0] NSEL_FETCH    = 3'b001;
    localparam logic [2:0] NSEL_JUMP     = 3'b010;
    localparam logic [2:0] NSEL_INC      = 3'b011;
    localparam logic [2:0] NSEL_CBRANCH  = 3'b100;
    localparam logic [2:0] NSEL_WAIT     = 3'b101;
    localparam logic [2:0] NSEL_CDECODE  = 3'b110;
    localparam logic [2:0] NSEL_RESERVED = 3'b111;

    // Condition selects
    localparam logic [1:0] COND_MOC      = 2'b00;
    localparam logic [1:0] COND_ZERO     = 2'b01;
    localparam logic [1:0] COND_NEG      = 2'b10;
    localparam logic [1:0] COND_ONE      = 2'b11;

    // Microstore state numbers (first state of each instruction routine)
    localparam logic [6:0] ST_RESET      = 7'd0;
    localparam logic [6:0] ST_FETCH      = 7'd1;
    localparam logic [6:0] ST_RTYPE      = 7'd6;
    localparam logic [6:0] ST_LW         = 7'd7;
    localparam logic [6:0] ST_BEQ        = 7'd11;
    localparam logic [6:0] ST_J          = 7'd12;
    localparam logic [6:0] ST_SW         = 7'd13;
    localparam logic [6:0] ST_ADDI       = 7'd17;
    localparam logic [6:0] ST_ANDI       = 7'd18;
    localparam logic [6:0] ST_LUI        = 7'd19;
    localparam logic [6:0] ST_ORI        = 7'd20;
    localparam logic [6:0] ST_BNE        = 7'd21;
    localparam logic [6:0] ST_JAL        = 7'd22;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE      = 6'h00;
    localparam logic [5:0] OP_J          = 6'h02;
    localparam logic [5:0] OP_JAL        = 6'h03;
    localparam logic [5:0] OP_BEQ        = 6'h04;
    localparam logic [5:0] OP_BNE        = 6'h05;
    localparam logic [5:0] OP_ADDI       = 6'h08;
    localparam logic [5:0] OP_ANDI       = 6'h0C;
    localparam logic [5:0] OP_ORI        = 6'h0D;
    localparam logic [5:0] OP_LUI        = 6'h0F;
    localparam logic [5:0] OP_LW         = 6'h23;
    localparam logic [5:0] OP_SW         = 6'h2B;

    // IR[5:0] funct codes accepted for R-type
    localparam logic [5:0] FN_ADD        = 6'h20;
    localparam logic [5:0] FN_ADDU       = 6'h21;
    localparam logic [5:0] FN_SUB        = 6'h22;
    localparam logic [5:0] FN_SUBU       = 6'h23;
    localparam logic [5:0] FN_AND        = 6'h24;
    localparam logic [5:0] FN_OR         = 6'h25;
    localparam logic [5:0] FN_SLT        = 6'h2A;

    // True for the R-type funct codes the datapath implements
    function automatic logic is_rtype_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_ADDU) || (fn == FN_SUB) ||
               (fn == FN_SUBU) || (fn == FN_AND) || (fn == FN_OR) ||
               (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Instruction encoder: maps IR opcode/funct to the first microstore state of
// the instruction's routine. valid=0 marks an undecodable instruction.
module instr_encoder
    import micro_seq_pkg::*;
#(
    parameter int STATE_W = 7
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               valid,
    output logic [STATE_W-1:0] target
);

    // Fixed decode table; a miss reports valid=0 with a reset-state target
    always_comb begin
        valid  = 1'b1;
        target = STATE_W'(ST_RESET);
        case (opcode)
            OP_RTYPE: begin
                if (is_rtype_funct(funct)) begin
                    target = STATE_W'(ST_RTYPE);
                end else begin
                    valid = 1'b0;
                end
            end
            OP_LW:   target = STATE_W'(ST_LW);
            OP_SW:   target = STATE_W'(ST_SW);
            OP_BEQ:  target = STATE_W'(ST_BEQ);
            OP_J:    target = STATE_W'(ST_J);
            OP_ADDI: target = STATE_W'(ST_ADDI);
            OP_ANDI: target = STATE_W'(ST_ANDI);
            OP_ORI:  target = STATE_W'(ST_ORI);
            OP_LUI:  target = STATE_W'(ST_LUI);
            OP_BNE:  target = STATE_W'(ST_BNE);
            OP_JAL:  target = STATE_W'(ST_JAL);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-state engine for the microprogrammed MIPS control unit. The state
// register addresses a combinational microstore whose fields come back on
// n_sel/inv/cond_sel/cr and choose the successor state each cycle.
//
// Memory handshake: a WAIT microinstruction holds its state while the
// selected condition (normally moc) is false and advances on the first
// cycle it is sampled true at posedge clk; moc needs no acknowledge. A
// watchdog bounds the hold to TIMEOUT cycles, after which the sequencer
// returns to RESET_STATE and raises the sticky mem_timeout flag.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int STATE_W     = 7,
    parameter int MAX_STATE   = 22,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         n_sel,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic [STATE_W-1:0] cr,
    input  logic               moc,
    input  logic               alu_zero,
    input  logic               alu_neg,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic [STATE_W-1:0] state,
    output logic               illegal_op,
    output logic               mem_timeout
);

    localparam logic [STATE_W-1:0] RST_ST   = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_ST = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] MAX_ST   = STATE_W'(MAX_STATE);
    // The watchdog fires on the TIMEOUT-th consecutive held cycle, i.e.
    // when the count of previous holds is already TIMEOUT-1.
    localparam logic [7:0]         WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic               enc_valid;
    logic [STATE_W-1:0] enc_st;
    logic               cond_raw;
    logic               cond_true;
    logic [STATE_W-1:0] inc_st;
    logic               cr_ok;
    logic [STATE_W-1:0] mode_next;
    logic               mode_illegal;
    logic               hold;
    logic               wd_fire;
    logic [STATE_W-1:0] next_state;
    logic [7:0]         wait_cnt;
    logic [7:0]         wait_cnt_next;

    instr_encoder #(
        .STATE_W (STATE_W)
    ) u_encoder (
        .opcode (opcode),
        .funct  (funct),
        .valid  (enc_valid),
        .target (enc_st)
    );

    // Condition mux, optional inversion, wrapping increment and target check
    always_comb begin
        case (cond_sel)
            COND_MOC:  cond_raw = moc;
            COND_ZERO: cond_raw = alu_zero;
            COND_NEG:  cond_raw = alu_neg;
            default:   cond_raw = 1'b1;
        endcase
        cond_true = cond_raw ^ inv;
        inc_st    = (state == MAX_ST) ? RST_ST : state + 1'b1;
        cr_ok     = (cr <= MAX_ST);
    end

    // Next-address mode mux; any unusable target collapses to RESET_STATE
    always_comb begin
        mode_next    = RST_ST;
        mode_illegal = 1'b0;
        hold         = 1'b0;
        case (n_sel)
            NSEL_DECODE: begin
                if (enc_valid) mode_next = enc_st;
                else           mode_illegal = 1'b1;
            end
            NSEL_FETCH: mode_next = FETCH_ST;
            NSEL_JUMP: begin
                if (cr_ok) mode_next = cr;
                else       mode_illegal = 1'b1;
            end
            NSEL_INC: mode_next = inc_st;
            NSEL_CBRANCH: begin
                if (!cond_true)  mode_next = inc_st;
                else if (cr_ok)  mode_next = cr;
                else             mode_illegal = 1'b1;
            end
            NSEL_WAIT: begin
                if (cond_true) begin
                    mode_next = inc_st;
                end else begin
                    mode_next = state;
                    hold      = 1'b1;
                end
            end
            NSEL_CDECODE: begin
                if (cond_true) begin
                    if (cr_ok) mode_next = cr;
                    else       mode_illegal = 1'b1;
                end else begin
                    if (enc_valid) mode_next = enc_st;
                    else           mode_illegal = 1'b1;
                end
            end
            default: mode_illegal = 1'b1;
        endcase
    end

    // Watchdog override: a hold that reaches the limit abandons the access
    always_comb begin
        wd_fire       = hold && (wait_cnt >= WAIT_LIMIT);
        next_state    = wd_fire ? RST_ST : mode_next;
        wait_cnt_next = (hold && !wd_fire) ? wait_cnt + 8'd1 : 8'd0;
    end

    // State register, watchdog counter and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RST_ST;
            wait_cnt    <= 8'd0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state      <= next_state;
            wait_cnt   <= wait_cnt_next;
            illegal_op <= mode_illegal;
            if (wd_fire) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed checks with literal expectations plus
// randomized microprograms checked every cycle against a behavioural model.
module tb_micro_sequencer;
    import micro_seq_pkg::*;

    localparam int TO = 15;

    logic       clk;
    logic       reset;
    logic [2:0] n_sel;
    logic       inv;
    logic [1:0] cond_sel;
    logic [6:0] cr;
    logic       moc;
    logic       alu_zero;
    logic       alu_neg;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [6:0] state;
    logic       illegal_op;
    logic       mem_timeout;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_state = 0;
    int m_wait  = 0;
    bit m_ill   = 0;
    bit m_to    = 0;
    logic [8:0] exp_q[$];

    // Random microstore image: one entry per valid state
    logic [2:0] rom_nsel [0:22];
    logic       rom_inv  [0:22];
    logic [1:0] rom_cs   [0:22];
    logic [6:0] rom_cr   [0:22];

    micro_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .n_sel       (n_sel),
        .inv         (inv),
        .cond_sel    (cond_sel),
        .cr          (cr),
        .moc         (moc),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .opcode      (opcode),
        .funct       (funct),
        .state       (state),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Instruction table from the ISA listing; -1 means undecodable
    function automatic int enc_model(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A}) ? 6 : -1;
            6'h23: return 7;
            6'h2B: return 13;
            6'h04: return 11;
            6'h02: return 12;
            6'h08: return 17;
            6'h0C: return 18;
            6'h0D: return 20;
            6'h0F: return 19;
            6'h05: return 21;
            6'h03: return 22;
            default: return -1;
        endcase
    endfunction

    // Reference model: successor computed from the mode rules, with any
    // target outside 0..22 meaning "illegal, go to 0"
    always @(posedge clk or negedge reset) begin
        int  tgt;
        bit  c;
        int  nxt;
        if (!reset) begin
            m_state = 0;
            m_wait  = 0;
            m_ill   = 0;
            m_to    = 0;
            exp_q.delete();
            exp_q.push_back({m_to, m_ill, 7'(m_state)});
        end else begin
            case (cond_sel)
                2'd0: c = moc;
                2'd1: c = alu_zero;
                2'd2: c = alu_neg;
                default: c = 1'b1;
            endcase
            c   = c ^ inv;
            nxt = (m_state + 1) % 23;
            tgt = -2;  // -2: hold in WAIT
            case (n_sel)
                3'd0: tgt = enc_model(opcode, funct);
                3'd1: tgt = 1;
                3'd2: tgt = int'(cr);
                3'd3: tgt = nxt;
                3'd4: tgt = c ? int'(cr) : nxt;
                3'd5: tgt = c ? nxt : -2;
                3'd6: tgt = c ? int'(cr) : enc_model(opcode, funct);
                default: tgt = -1;
            endcase
            m_ill = 0;
            if (tgt == -2) begin
                m_wait++;
                if (m_wait == TO) begin
                    m_state = 0;
                    m_wait  = 0;
                    m_to    = 1;
                end
            end else begin
                m_wait = 0;
                if (tgt < 0 || tgt > 22) begin
                    m_ill   = 1;
                    m_state = 0;
                end else begin
                    m_state = tgt;
                end
            end
            exp_q.push_back({m_to, m_ill, 7'(m_state)});
        end
    end

    // Per-cycle compare against the model's expectation
    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cyc_state", 32'(state), 32'(e[6:0]));
            check("cyc_illegal", 32'(illegal_op), 32'(e[7]));
            check("cyc_timeout", 32'(mem_timeout), 32'(e[8]));
        end
    end

    // ---------------- drivers ----------------
    task automatic apply(input logic [2:0] ns, input logic iv, input logic [1:0] cs,
                         input logic [6:0] c, input logic m, input logic az,
                         input logic [5:0] op, input logic [5:0] fn);
        n_sel = ns; inv = iv; cond_sel = cs; cr = c; moc = m;
        alu_zero = az; alu_neg = 1'b0; opcode = op; funct = fn;
    endtask

    // Waits one clock and checks outputs against literal values
    task automatic expect_out(input string name, input int s, input bit il, input bit to);
        @(negedge clk);
        #1;
        check({name, "_state"}, 32'(state), 32'(s));
        check({name, "_illegal"}, 32'(illegal_op), 32'(il));
        check({name, "_timeout"}, 32'(mem_timeout), 32'(to));
    endtask

    // Reset for three cycles; leaves inputs at FETCH and time at negedge+1
    task automatic reset_dut();
        reset = 1'b0;
        apply(NSEL_FETCH, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b1;
    endtask

    task automatic build_rom();
        for (int i = 0; i <= 22; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 4)       rom_nsel[i] = NSEL_WAIT;
            else if (r < 6)  rom_nsel[i] = NSEL_INC;
            else if (r < 8)  rom_nsel[i] = NSEL_DECODE;
            else if (r < 10) rom_nsel[i] = NSEL_CBRANCH;
            else if (r < 12) rom_nsel[i] = NSEL_CDECODE;
            else if (r < 13) rom_nsel[i] = NSEL_JUMP;
            else if (r < 14) rom_nsel[i] = NSEL_FETCH;
            else             rom_nsel[i] = 3'($urandom_range(0, 7));
            rom_inv[i] = ($urandom_range(0, 3) == 0);
            rom_cs[i]  = 2'($urandom_range(0, 3));
            rom_cr[i]  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(23, 127))
                                                     : 7'($urandom_range(0, 22));
        end
        rom_cs[0]   = COND_MOC;
        rom_nsel[0] = NSEL_WAIT;  // guarantees a watchdog-prone state exists
    endtask

    task automatic drive_random_cycle();
        logic [5:0] ops [0:10];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h05, 6'h03};
        n_sel    = rom_nsel[m_state];
        inv      = rom_inv[m_state];
        cond_sel = rom_cs[m_state];
        cr       = rom_cr[m_state];
        moc      = ($urandom_range(0, 7) == 0);
        alu_zero = 1'($urandom_range(0, 1));
        alu_neg  = 1'($urandom_range(0, 1));
        opcode   = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 10)] : 6'($urandom);
        funct    = ($urandom_range(0, 1) != 0) ? 6'h20 + 6'($urandom_range(0, 5)) : 6'($urandom);
        @(negedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        apply(NSEL_FETCH, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        @(negedge clk);
        #1;
        reset_dut();

        // WAIT on moc: three holds then advance
        apply(NSEL_FETCH, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("fetch", 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 0, 0, 6'h00, 6'h00);
            expect_out("wait_hold", 1, 0, 0);
        end
        apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 1, 0, 6'h00, 6'h00);
        expect_out("wait_go", 2, 0, 0);

        // DECODE
        apply(NSEL_DECODE, 0, COND_ONE, 7'd0, 0, 0, 6'h23, 6'h00);
        expect_out("dec_lw", 7, 0, 0);
        apply(NSEL_DECODE, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h20);
        expect_out("dec_add", 6, 0, 0);
        apply(NSEL_DECODE, 0, COND_ONE, 7'd0, 0, 0, 6'h3F, 6'h00);
        expect_out("dec_bad", 0, 1, 0);
        apply(NSEL_FETCH, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("ill_drop", 1, 0, 0);

        // CBRANCH on alu_zero, with and without inversion
        apply(NSEL_CBRANCH, 0, COND_ZERO, 7'd12, 0, 1, 6'h00, 6'h00);
        expect_out("br_taken", 12, 0, 0);
        apply(NSEL_CBRANCH, 0, COND_ZERO, 7'd5, 0, 0, 6'h00, 6'h00);
        expect_out("br_not", 13, 0, 0);
        apply(NSEL_CBRANCH, 1, COND_ZERO, 7'd5, 0, 1, 6'h00, 6'h00);
        expect_out("br_inv_not", 14, 0, 0);
        apply(NSEL_CBRANCH, 1, COND_ZERO, 7'd3, 0, 0, 6'h00, 6'h00);
        expect_out("br_inv_taken", 3, 0, 0);

        // Watchdog: 15th consecutive held cycle returns to 0
        apply(NSEL_JUMP, 0, COND_ONE, 7'd4, 0, 0, 6'h00, 6'h00);
        expect_out("jump4", 4, 0, 0);
        for (int i = 0; i < TO - 1; i++) begin
            apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 0, 0, 6'h00, 6'h00);
            expect_out("wd_hold", 4, 0, 0);
        end
        apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("wd_fire", 0, 0, 1);
        apply(NSEL_FETCH, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("wd_sticky", 1, 0, 1);
        reset_dut();

        // moc on the 15th cycle wins over the watchdog
        apply(NSEL_JUMP, 0, COND_ONE, 7'd4, 0, 0, 6'h00, 6'h00);
        expect_out("jump4b", 4, 0, 0);
        for (int i = 0; i < TO - 1; i++) begin
            apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 0, 0, 6'h00, 6'h00);
            expect_out("wd2_hold", 4, 0, 0);
        end
        apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 1, 0, 6'h00, 6'h00);
        expect_out("wd_moc_late", 5, 0, 0);

        // Reset mid-WAIT takes effect without a clock edge
        apply(NSEL_JUMP, 0, COND_ONE, 7'd9, 0, 0, 6'h00, 6'h00);
        expect_out("jump9", 9, 0, 0);
        apply(NSEL_WAIT, 0, COND_MOC, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("hold9", 9, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        apply(NSEL_JUMP, 0, COND_ONE, 7'd22, 0, 0, 6'h00, 6'h00);
        expect_out("jump22", 22, 0, 0);

        // INC wrap, reserved mode, back-to-back pulses, out-of-range jump
        apply(NSEL_INC, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("inc_wrap", 0, 0, 0);
        apply(NSEL_RESERVED, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("rsv1", 0, 1, 0);
        apply(NSEL_RESERVED, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("rsv2", 0, 1, 0);
        apply(NSEL_FETCH, 0, COND_ONE, 7'd0, 0, 0, 6'h00, 6'h00);
        expect_out("rsv_drop", 1, 0, 0);
        apply(NSEL_JUMP, 0, COND_ONE, 7'd100, 0, 0, 6'h00, 6'h00);
        expect_out("jump_bad", 0, 1, 0);

        // Randomized microprograms
        for (int ep = 0; ep < 6; ep++) begin
            reset_dut();
            build_rom();
            for (int cyc = 0; cyc < 400; cyc++) begin
                drive_random_cycle();
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
